// File: rtl/memory_bus_bram_slave_if.sv
// MemoryBus link between one requester (master) and one memory endpoint (slave).
// ms* carries requests toward the slave; sm* carries read responses back.
interface memory_bus_bram_slave_if #(
    parameter int MASTER_ID_WIDTH = 8,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 16
);

    logic [MASTER_ID_WIDTH-1:0] msID;
    logic [ADDRESS_WIDTH-1:0]   msAddress;
    logic [DATA_WIDTH-1:0]      msData;
    logic                       msWrite;
    logic                       msValid;
    logic                       msReady;

    logic [MASTER_ID_WIDTH-1:0] smID;
    logic [DATA_WIDTH-1:0]      smData;
    logic                       smValid;
    logic                       smReady;

    modport master (
        output msID, msAddress, msData, msWrite, msValid, smReady,
        input  msReady, smID, smData, smValid
    );

    modport slave (
        input  msID, msAddress, msData, msWrite, msValid, smReady,
        output msReady, smID, smData, smValid
    );

endinterface

// File: rtl/memory_bus_bram_slave.sv
// Block-RAM MemoryBus slave: writes land in RAM, reads return through a credit-managed FWFT response FIFO.
// Define MEMORY_BUS_BOUNDS_CHECK_EN to drop out-of-range writes and answer out-of-range reads with all-ones.
module memory_bus_bram_slave #(
    parameter int MASTER_ID_WIDTH = 8,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 16,
    parameter int DEPTH           = 1024,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    memory_bus_bram_slave_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0] CREDITS = OCC_W'(FIFO_DEPTH);

    // Request side
    logic             ms_ready;
    logic             ms_fire;
    logic             rd_issue;
    logic             wr_en;
    logic             in_range;
    logic             unused_addr_hi;
    logic [IDX_W-1:0] idx;

    assign ms_fire        = bus.msValid && ms_ready;
    assign rd_issue       = ms_fire && !bus.msWrite;
    assign idx            = bus.msAddress[IDX_W-1:0];
    assign unused_addr_hi = ^(bus.msAddress >> IDX_W);

`ifdef MEMORY_BUS_BOUNDS_CHECK_EN
    assign in_range = (bus.msAddress >> IDX_W) == '0;
`else
    assign in_range = 1'b1;
`endif

    assign wr_en = ms_fire && bus.msWrite && in_range;

    // Synchronous single-port RAM
    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;

    // NOTE: the RAM array and its output register have no reset so they map onto
    // block RAM; the pipeline valid bit below is the only thing that needs clearing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[idx] <= bus.msData;
        end
        if (rd_issue) begin
            ram_q <= ram[idx];
        end
    end

    // One-deep read pipeline: ID travels alongside the RAM access
    logic                       rd_pending;
    logic [MASTER_ID_WIDTH-1:0] rd_id;
`ifdef MEMORY_BUS_BOUNDS_CHECK_EN
    logic                       rd_oob;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending <= 1'b0;
            rd_id      <= '0;
`ifdef MEMORY_BUS_BOUNDS_CHECK_EN
            rd_oob     <= 1'b0;
`endif
        end else begin
            rd_pending <= rd_issue;
            if (rd_issue) begin
                rd_id  <= bus.msID;
`ifdef MEMORY_BUS_BOUNDS_CHECK_EN
                rd_oob <= !in_range;
`endif
            end
        end
    end

    logic [DATA_WIDTH-1:0] push_data;

`ifdef MEMORY_BUS_BOUNDS_CHECK_EN
    assign push_data = rd_oob ? '1 : ram_q;
`else
    assign push_data = ram_q;
`endif

    // Response FIFO (first-word-fall-through)
    logic [DATA_WIDTH-1:0]      fifo_data [FIFO_DEPTH];
    logic [MASTER_ID_WIDTH-1:0] fifo_id   [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [OCC_W-1:0]           count;
    logic [OCC_W-1:0]           count_nxt;
    logic [OCC_W-1:0]           occ_nxt;
    logic                       push;
    logic                       pop;
    logic                       empty;

    assign push  = rd_pending;
    assign empty = (count == '0);
    assign pop   = !empty && bus.smReady;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_id[wr_ptr]   <= rd_id;
        end
    end

    // NOTE: count_nxt gets its default before the case so this block stays purely
    // combinational; leaving any path unassigned would infer a latch.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // A read issued this edge occupies the pipeline next cycle, so it already holds a credit.
    assign occ_nxt = count_nxt + OCC_W'(rd_issue);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ms_ready <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            end
            if (pop) begin
                rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            end
            count    <= count_nxt;
            ms_ready <= (occ_nxt < CREDITS);
        end
    end

    assign bus.msReady = ms_ready;
    assign bus.smValid = !empty;
    assign bus.smData  = empty ? '0 : fifo_data[rd_ptr];
    assign bus.smID    = empty ? '0 : fifo_id[rd_ptr];

endmodule

// File: tb/tb_memory_bus_bram_slave.sv
// Self-checking bench for memory_bus_bram_slave: table-driven vectors plus back-pressure,
// streaming, push/pop and reset sequences; read responses are checked against a scoreboard queue.
module tb_memory_bus_bram_slave;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [15:0] data;
        logic [7:0]  id;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0]  id;
        logic [15:0] data;
    } resp_t;

`ifdef MEMORY_BUS_BOUNDS_CHECK_EN
    localparam logic [15:0] EXP_OOR_1029 = 16'hFFFF;
    localparam logic [15:0] EXP_AT5_POST = 16'hBEEF;
    localparam logic [15:0] EXP_OOR_2047 = 16'hFFFF;
`else
    localparam logic [15:0] EXP_OOR_1029 = 16'hBEEF;
    localparam logic [15:0] EXP_AT5_POST = 16'h5555;
    localparam logic [15:0] EXP_OOR_2047 = 16'hAAAA;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   resp_cnt;
    int   pop_cycs [$];
    resp_t exp_q [$];
    resp_t mon_e;
    vec_t  vecs [12];

    memory_bus_bram_slave_if #(.MASTER_ID_WIDTH(8), .ADDRESS_WIDTH(32), .DATA_WIDTH(16)) bus ();

    memory_bus_bram_slave #(
        .MASTER_ID_WIDTH(8),
        .ADDRESS_WIDTH  (32),
        .DATA_WIDTH     (16),
        .DEPTH          (1024),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [15:0] pat(input int a);
        return 16'h3C00 + 16'(a * 7);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Response monitor: a beat presented with smReady high at the negedge is consumed at the next posedge.
    always @(negedge clk) begin
        if (rst_n && bus.smValid && bus.smReady) begin
            pop_cycs.push_back(cyc);
            resp_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_resp got id=%h data=%h exp=none", bus.smID, bus.smData);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.smID !== mon_e.id || bus.smData !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL resp_order got id=%h data=%h exp id=%h data=%h",
                             bus.smID, bus.smData, mon_e.id, mon_e.data);
                end
            end
        end
    end

    // Drive one request and hold it until handshaken; returns at posedge+1 with msValid still high.
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [15:0] data,
                         input logic [7:0] id, input logic [15:0] exp, output int waited);
        waited        = 0;
        bus.msValid   = 1'b1;
        bus.msWrite   = wr;
        bus.msAddress = addr;
        bus.msData    = data;
        bus.msID      = id;
        @(negedge clk);
        while (!bus.msReady && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.msReady) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout got=stalled exp=accepted addr=%h", addr);
        end else if (!wr) begin
            exp_q.push_back('{id: id, data: exp});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.msValid = 1'b0;
        bus.msWrite = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.smValid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int tw;
        int base;

        vecs[0]  = '{1'b1, 32'd5,    16'h1234, 8'h00, 16'h0000};
        vecs[1]  = '{1'b0, 32'd5,    16'h0000, 8'h3A, 16'h1234};
        vecs[2]  = '{1'b1, 32'd6,    16'h0F0F, 8'h00, 16'h0000};
        vecs[3]  = '{1'b0, 32'd6,    16'h0000, 8'h01, 16'h0F0F};
        vecs[4]  = '{1'b1, 32'd5,    16'hBEEF, 8'h00, 16'h0000};
        vecs[5]  = '{1'b0, 32'd1029, 16'h0000, 8'h07, EXP_OOR_1029};
        vecs[6]  = '{1'b1, 32'd1029, 16'h5555, 8'h00, 16'h0000};
        vecs[7]  = '{1'b0, 32'd5,    16'h0000, 8'h08, EXP_AT5_POST};
        vecs[8]  = '{1'b0, 32'd0,    16'h0000, 8'hFF, pat(0)};
        vecs[9]  = '{1'b1, 32'd1023, 16'hAAAA, 8'h00, 16'h0000};
        vecs[10] = '{1'b0, 32'd1023, 16'h0000, 8'h0C, 16'hAAAA};
        vecs[11] = '{1'b0, 32'd2047, 16'h0000, 8'h0D, EXP_OOR_2047};

        n_checks      = 0;
        n_fail        = 0;
        resp_cnt      = 0;
        rst_n         = 1'b0;
        bus.msValid   = 1'b0;
        bus.msWrite   = 1'b0;
        bus.msAddress = '0;
        bus.msData    = '0;
        bus.msID      = '0;
        bus.smReady   = 1'b0;

        // Reset state
        #12;
        check("rst_msReady", 32'(bus.msReady), 32'd0);
        check("rst_smValid", 32'(bus.smValid), 32'd0);
        check("rst_smID",    32'(bus.smID),    32'd0);
        check("rst_smData",  32'(bus.smData),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_msReady", 32'(bus.msReady), 32'd1);
        @(posedge clk);
        #1;

        // Preload addresses 0..31
        bus.smReady = 1'b1;
        for (int a = 0; a < 32; a++) issue(1'b1, 32'(a), pat(a), 8'h00, 16'h0000, w);
        idle();

        // Back-pressure: exactly four reads accepted, then stall
        bus.smReady = 1'b0;
        tw = 0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 32'(i), 16'h0000, 8'(8'h10 + i), pat(i), w);
            tw += w;
        end
        check("bp_four_accepted", 32'(tw), 32'd0);
        bus.msWrite   = 1'b0;
        bus.msAddress = 32'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_stalled_msReady", 32'(bus.msReady), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.smReady = 1'b1;
        issue(1'b0, 32'd4, 16'h0000, 8'h14, pat(4), w);
        issue(1'b0, 32'd5, 16'h0000, 8'h15, pat(5), w);
        idle();
        drain();

        // Streaming: 16 back-to-back reads, 16 gapless responses
        pop_cycs.delete();
        tw = 0;
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 32'(16 + i), 16'h0000, 8'(8'h40 + i), pat(16 + i), w);
            tw += w;
        end
        idle();
        drain();
        check("stream_no_stall", 32'(tw), 32'd0);
        check("stream_resp_count", 32'(pop_cycs.size()), 32'd16);
        if (pop_cycs.size() == 16)
            check("stream_gapless", 32'(pop_cycs[15] - pop_cycs[0]), 32'd15);
        else
            check("stream_gapless", 32'(pop_cycs.size()), 32'd16);

        // Same-edge push and pop with all credits in use
        bus.smReady = 1'b0;
        for (int i = 0; i < 4; i++) issue(1'b0, 32'(8 + i), 16'h0000, 8'(8'h80 + i), pat(8 + i), w);
        idle();
        check("pp_full_msReady", 32'(bus.msReady), 32'd0);
        bus.smReady = 1'b1;
        @(posedge clk);
        #1;
        bus.smReady = 1'b0;
        @(negedge clk);
        check("pp_credit_freed", 32'(bus.msReady), 32'd1);
        check("pp_still_valid",  32'(bus.smValid), 32'd1);
        check("pp_head_id",      32'(bus.smID),    32'h81);
        @(posedge clk);
        #1;
        bus.smReady = 1'b1;
        drain();

        // Table-driven vectors
        for (int i = 0; i < 12; i++)
            issue(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].id, vecs[i].exp, w);
        idle();
        drain();

        // Read latency after a write on the preceding edge
        issue(1'b1, 32'd5, 16'h1234, 8'h00, 16'h0000, w);
        issue(1'b0, 32'd5, 16'h0000, 8'h3A, 16'h1234, w);
        idle();
        @(negedge clk);
        check("lat_edge1_smValid", 32'(bus.smValid), 32'd0);
        @(negedge clk);
        check("lat_edge2_smValid", 32'(bus.smValid), 32'd1);
        check("lat_edge2_smData",  32'(bus.smData),  32'h1234);
        check("lat_edge2_smID",    32'(bus.smID),    32'h3A);
        @(posedge clk);
        #1;
        drain();

        // Reset mid-burst with two responses queued
        bus.smReady = 1'b0;
        issue(1'b0, 32'd16, 16'h0000, 8'hC0, pat(16), w);
        issue(1'b0, 32'd17, 16'h0000, 8'hC1, pat(17), w);
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("midrst_queued", 32'(bus.smValid), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_smValid", 32'(bus.smValid), 32'd0);
        check("midrst_msReady", 32'(bus.msReady), 32'd0);
        check("midrst_smData",  32'(bus.smData),  32'd0);
        exp_q.delete();
        bus.smReady = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_release_msReady", 32'(bus.msReady), 32'd1);
        base = resp_cnt;
        repeat (6) @(negedge clk);
        check("midrst_no_stale", 32'(resp_cnt - base), 32'd0);
        @(posedge clk);
        #1;
        issue(1'b0, 32'd18, 16'h0000, 8'hC2, pat(18), w);
        idle();
        drain();
        check("midrst_post_resp", 32'(resp_cnt - base), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
